// File: rtl/clock_ctrl.sv
// Digital clock timekeeping controller: 1 Hz prescaler, hh:mm:ss chain and set-mode FSM.
// Optional alarm (al_hour/al_min registers, AL_HOUR/AL_MIN states) is enabled by defining ALARM_EN.
module clock_ctrl #(
  parameter int unsigned TICK_DIV = 50000000,
  parameter int unsigned PRE_W    = 26
) (
  input  logic       clki,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic       tick_1hz,
  output logic [5:0] sec,
  output logic [5:0] min,
  output logic [4:0] hour,
  output logic [1:0] mode,
  output logic       blink,
  output logic       alarm
);

  typedef enum logic [2:0] {
    S_RUN      = 3'd0,
    S_SET_HOUR = 3'd1,
    S_SET_MIN  = 3'd2,
    S_AL_HOUR  = 3'd3,
    S_AL_MIN   = 3'd4
  } state_t;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  state_t           state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic             tick_q, tick_d;
  logic [5:0]       sec_q, sec_d;
  logic [5:0]       min_q, min_d;
  logic [4:0]       hour_q, hour_d;
  logic             blink_q, blink_d;

  // Next values of the time chain if a RUN tick is applied this cycle.
  logic [5:0]       sec_inc, min_inc;
  logic [4:0]       hour_inc;
  logic             sec_wrap, min_wrap;
  logic             exit_set;

`ifdef ALARM_EN
  localparam int unsigned AL_LEN = TICK_DIV * 60;
  localparam int unsigned AL_W   = $clog2(AL_LEN);

  logic [4:0]      al_hour_q, al_hour_d;
  logic [5:0]      al_min_q, al_min_d;
  logic            alarm_q, alarm_d;
  logic [AL_W-1:0] al_cnt_q, al_cnt_d;
`endif

  always_comb begin
    sec_wrap = (sec_q == 6'd59);
    min_wrap = (min_q == 6'd59);
    sec_inc  = sec_wrap ? '0 : sec_q + 6'd1;
    min_inc  = min_q;
    hour_inc = hour_q;
    if (sec_wrap) begin
      min_inc = min_wrap ? '0 : min_q + 6'd1;
      if (min_wrap) begin
        hour_inc = (hour_q == 5'd23) ? '0 : hour_q + 5'd1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    pre_d    = (pre_q == PRE_LAST) ? '0 : pre_q + PRE_W'(1);
    tick_d   = (pre_q == PRE_LAST);
    sec_d    = sec_q;
    min_d    = min_q;
    hour_d   = hour_q;
    blink_d  = blink_q;
    exit_set = 1'b0;
`ifdef ALARM_EN
    al_hour_d = al_hour_q;
    al_min_d  = al_min_q;
    alarm_d   = alarm_q;
    al_cnt_d  = al_cnt_q;
`endif

    // A tick in RUN is applied even when btn_mode freezes the counters on the same edge.
    if (state_q == S_RUN && tick_q) begin
      sec_d  = sec_inc;
      min_d  = min_inc;
      hour_d = hour_inc;
    end

    if (btn_mode) begin
      blink_d = 1'b0;
      case (state_q)
        S_RUN:      state_d = S_SET_HOUR;
        S_SET_HOUR: state_d = S_SET_MIN;
`ifdef ALARM_EN
        S_SET_MIN:  state_d = S_AL_HOUR;
        S_AL_HOUR:  state_d = S_AL_MIN;
        S_AL_MIN: begin
          state_d  = S_RUN;
          exit_set = 1'b1;
        end
`else
        S_SET_MIN: begin
          state_d  = S_RUN;
          exit_set = 1'b1;
        end
`endif
        default:    state_d = S_RUN;
      endcase
    end else begin
      if (btn_inc) begin
        case (state_q)
          S_SET_HOUR: hour_d = (hour_q == 5'd23) ? '0 : hour_q + 5'd1;
          S_SET_MIN:  min_d  = (min_q == 6'd59) ? '0 : min_q + 6'd1;
`ifdef ALARM_EN
          S_AL_HOUR:  al_hour_d = (al_hour_q == 5'd23) ? '0 : al_hour_q + 5'd1;
          S_AL_MIN:   al_min_d  = (al_min_q == 6'd59) ? '0 : al_min_q + 6'd1;
`endif
          default:    ;
        endcase
      end
      if (state_q == S_RUN) begin
        blink_d = 1'b0;
      end else if (tick_q) begin
        blink_d = ~blink_q;
      end
    end

    // Restart the second on leaving set mode so the first second is a full period.
    if (exit_set) begin
      sec_d  = '0;
      pre_d  = '0;
      tick_d = 1'b0;
    end

`ifdef ALARM_EN
    if (state_q == S_RUN && btn_inc && !btn_mode) begin
      alarm_d  = 1'b0;
      al_cnt_d = '0;
    end else if (state_q == S_RUN && tick_q && sec_wrap &&
                 hour_inc == al_hour_q && min_inc == al_min_q) begin
      alarm_d  = 1'b1;
      al_cnt_d = AL_W'(AL_LEN - 1);
    end else if (alarm_q) begin
      if (al_cnt_q == '0) begin
        alarm_d = 1'b0;
      end else begin
        al_cnt_d = al_cnt_q - AL_W'(1);
      end
    end
`endif
  end

  always_ff @(posedge clki or posedge rst) begin
    if (rst) begin
      state_q <= S_RUN;
      pre_q   <= '0;
      tick_q  <= 1'b0;
      sec_q   <= '0;
      min_q   <= '0;
      hour_q  <= '0;
      blink_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      tick_q  <= tick_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      hour_q  <= hour_d;
      blink_q <= blink_d;
    end
  end

`ifdef ALARM_EN
  always_ff @(posedge clki or posedge rst) begin
    if (rst) begin
      al_hour_q <= '0;
      al_min_q  <= '0;
      alarm_q   <= 1'b0;
      al_cnt_q  <= '0;
    end else begin
      al_hour_q <= al_hour_d;
      al_min_q  <= al_min_d;
      alarm_q   <= alarm_d;
      al_cnt_q  <= al_cnt_d;
    end
  end
`endif

  always_comb begin
    case (state_q)
      S_RUN:      mode = 2'd0;
      S_SET_HOUR: mode = 2'd1;
      S_SET_MIN:  mode = 2'd2;
      S_AL_HOUR:  mode = 2'd3;
      S_AL_MIN:   mode = 2'd3;
      default:    mode = 2'd0;
    endcase
  end

  assign tick_1hz = tick_q;
  assign sec      = sec_q;
  assign min      = min_q;
  assign hour     = hour_q;

`ifdef ALARM_EN
  // AL_MIN shares mode code 3 with AL_HOUR and is told apart by inverted blink phase.
  assign blink = blink_q ^ (state_q == S_AL_MIN);
  assign alarm = alarm_q;
`else
  assign blink = blink_q;
  assign alarm = 1'b0;
`endif

endmodule

// File: tb/tb_clock_ctrl.sv
// Self-checking bench for clock_ctrl (default build) against a seconds-of-day reference model.
module tb_clock_ctrl;

  localparam int TD = 4;

  logic       clki;
  logic       rst;
  logic       btn_mode;
  logic       btn_inc;
  logic       tick_1hz;
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hour;
  logic [1:0] mode;
  logic       blink;
  logic       alarm;

  clock_ctrl #(.TICK_DIV(TD), .PRE_W(3)) dut (
    .clki(clki), .rst(rst), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .tick_1hz(tick_1hz), .sec(sec), .min(min), .hour(hour),
    .mode(mode), .blink(blink), .alarm(alarm)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  // Reference state: time as seconds of day, edges since the second was (re)started.
  int m_time;
  int m_mode;
  int m_cnt;
  bit m_tick;
  bit m_blink;

  initial begin
    clki = 0;
    forever #5 clki = ~clki;
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_time = 0; m_mode = 0; m_cnt = 0; m_tick = 0; m_blink = 0;
  endtask

  task automatic model_edge(input bit bm, input bit bi);
    bit t;
    int om, h, mi, s;
    t  = m_tick;
    om = m_mode;
    if (om == 0 && t) m_time = (m_time + 1) % 86400;
    h  = m_time / 3600;
    mi = (m_time / 60) % 60;
    s  = m_time % 60;
    if (!bm && bi) begin
      if (om == 1) h = (h + 1) % 24;
      else if (om == 2) mi = (mi + 1) % 60;
    end
    m_cnt++;
    if (bm) begin
      m_mode  = (om + 1) % 3;
      m_blink = 0;
      if (om == 2) begin
        s     = 0;
        m_cnt = 0;
      end
    end else if (om == 0) begin
      m_blink = 0;
    end else if (t) begin
      m_blink = !m_blink;
    end
    m_time = h * 3600 + mi * 60 + s;
    m_tick = (m_cnt > 0) && (m_cnt % TD == 0);
  endtask

  always @(negedge clki) begin
    if (chk_en) begin
      check("tick", int'(tick_1hz), int'(m_tick));
      check("sec",  int'(sec),  m_time % 60);
      check("min",  int'(min),  (m_time / 60) % 60);
      check("hour", int'(hour), m_time / 3600);
      check("mode", int'(mode), m_mode);
      check("blink", int'(blink), int'(m_blink));
      check("alarm", int'(alarm), 0);
    end
  end

  task automatic step(input bit bm, input bit bi);
    btn_mode = bm;
    btn_inc  = bi;
    @(posedge clki);
    model_edge(bm, bi);
    #1;
    btn_mode = 0;
    btn_inc  = 0;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step(0, 0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_sec"},   int'(sec), 0);
    check({tag, "_min"},   int'(min), 0);
    check({tag, "_hour"},  int'(hour), 0);
    check({tag, "_mode"},  int'(mode), 0);
    check({tag, "_blink"}, int'(blink), 0);
    check({tag, "_tick"},  int'(tick_1hz), 0);
  endtask

  initial begin
    rst = 1; btn_mode = 0; btn_inc = 0;
    model_reset();
    #1;
    check_zero("reset");
    @(posedge clki);
    @(negedge clki);
    rst = 0;
    chk_en = 1;

    // First period: tick on the 4th edge, sec becomes 1 on the 5th.
    steps(3);
    check("pin_notick3", int'(tick_1hz), 0);
    step(0, 0);
    check("pin_tick4", int'(tick_1hz), 1);
    check("pin_sec_at_tick", int'(sec), 0);
    step(0, 0);
    check("pin_sec1", int'(sec), 1);
    check("pin_tick_low", int'(tick_1hz), 0);
    steps(3);
    check("pin_tick8", int'(tick_1hz), 1);

    // Preload 23:59:xx with sec reset to 0 on exit, then run across midnight.
    step(1, 0);
    for (int i = 0; i < 23; i++) step(0, 1);
    step(1, 0);
    for (int i = 0; i < 59; i++) step(0, 1);
    step(1, 0);
    check("pin_exit_sec", int'(sec), 0);
    steps(233);
    check("pin_58_sec", int'(sec), 58);
    steps(4);
    check("pin_59_sec", int'(sec), 59);
    check("pin_59_min", int'(min), 59);
    check("pin_59_hour", int'(hour), 23);
    steps(4);
    check("pin_mid_sec", int'(sec), 0);
    check("pin_mid_min", int'(min), 0);
    check("pin_mid_hour", int'(hour), 0);

    // Hour set with wrap: 25 increments from 0 gives 1.
    step(1, 0);
    for (int i = 0; i < 25; i++) step(0, 1);
    check("pin_sethour_mode", int'(mode), 1);
    check("pin_sethour_hour", int'(hour), 1);

    // Minute wrap without carry, then exit restarts the second.
    step(1, 0);
    for (int i = 0; i < 59; i++) step(0, 1);
    check("pin_min59", int'(min), 59);
    step(0, 1);
    check("pin_minwrap", int'(min), 0);
    check("pin_minwrap_hour", int'(hour), 1);
    step(1, 0);
    check("pin_exit_mode", int'(mode), 0);
    check("pin_exit_sec0", int'(sec), 0);
    check("pin_exit_notick", int'(tick_1hz), 0);
    steps(3);
    check("pin_exit_notick3", int'(tick_1hz), 0);
    step(0, 0);
    check("pin_exit_tick4", int'(tick_1hz), 1);

    // Mode press on the tick cycle in RUN: tick applied, then freeze.
    step(1, 0);
    check("pin_tickmode_mode", int'(mode), 1);
    for (int i = 0; i < 2; i++) step(1, 0);

    // Randomised buttons.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 5) == 0));
    end

    // Back to RUN, then simultaneous mode + inc.
    for (int i = 0; i < 3 && m_mode != 0; i++) step(1, 0);
    check("pin_in_run", int'(mode), 0);
    steps(2);
    step(1, 1);
    check("pin_both_mode", int'(mode), 1);
    check("pin_both_hour", int'(hour), m_time / 3600);

    // Asynchronous reset mid SET_MIN.
    step(1, 0);
    steps(6);
    step(0, 1);
    check("pin_setmin_mode", int'(mode), 2);
    #2;
    chk_en = 0;
    rst = 1;
    #1;
    model_reset();
    check_zero("async");
    @(posedge clki);
    @(negedge clki);
    rst = 0;
    chk_en = 1;
    steps(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
